// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and direction encoding for the button position block
package button_pkg;

    localparam int          DB_BITS_DEF       = 16;
    localparam logic [23:0] REPEAT_DELAY_DEF  = 24'd6_000_000;
    localparam logic [23:0] REPEAT_PERIOD_DEF = 24'd1_500_000;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-button synchroniser, counter debouncer and press detector
module btn_debounce
    import button_pkg::*;
#(
    parameter int DB_BITS = DB_BITS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic state,
    output logic press
);

    logic               sync_q, sync_d;
    logic               state_q, state_d;
    logic               prev_q, prev_d;
    logic [DB_BITS-1:0] cnt_q, cnt_d;

    // Count how long the synchronised level has disagreed with the debounced state;
    // the state only flips after the counter has run all the way to all-ones.
    always_comb begin
        sync_d  = ~button;
        prev_d  = state_q;
        state_d = state_q;
        cnt_d   = '0;
        if (sync_q != state_q) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = ~state_q;
            end
        end
    end

    // State registers for synchroniser, counter, debounced level and its delayed copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b0;
            state_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign press = state_q & ~prev_q;

endmodule

// File: rtl/button_position.sv
// rtl/button_position.sv - two-button one-hot position controller; BUTTON_REPEAT_EN enables hold-to-repeat
module button_position
    import button_pkg::*;
#(
    parameter int          WIDTH         = 4,
    parameter int          DB_BITS       = DB_BITS_DEF,
    parameter bit          WRAP          = 1'b1,
    parameter logic [23:0] REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter logic [23:0] REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     button1,
    input  logic                     button2,
    output logic [WIDTH-1:0]         led,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     step
);

    localparam int             PW      = $clog2(WIDTH);
    localparam logic [PW-1:0]  POS_MAX = PW'(WIDTH - 1);

    // Index 0 is the left button, index 1 the right button.
    logic [1:0] st;
    logic [1:0] prs;
    logic [1:0] rep;
    logic       both_held;
    dir_t       dir;

    logic [PW-1:0] pos_q, pos_d;
    logic          step_q, step_d;

    btn_debounce #(.DB_BITS(DB_BITS)) u_db_left (
        .clk    (clk),
        .rst    (rst),
        .button (button1),
        .state  (st[0]),
        .press  (prs[0])
    );

    btn_debounce #(.DB_BITS(DB_BITS)) u_db_right (
        .clk    (clk),
        .rst    (rst),
        .button (button2),
        .state  (st[1]),
        .press  (prs[1])
    );

    assign both_held = st[0] & st[1];

`ifdef BUTTON_REPEAT_EN
    logic [1:0][23:0] hold_q, hold_d;
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       first_q, first_d;

    // Per-button hold timers: armed by a press, first repeat after REPEAT_DELAY,
    // then every REPEAT_PERIOD; restarted from scratch while both buttons are held.
    always_comb begin
        hold_d  = hold_q;
        armed_d = armed_q;
        first_d = first_q;
        rep     = 2'b00;
        for (int b = 0; b < 2; b++) begin
            if (!st[b]) begin
                armed_d[b] = 1'b0;
                hold_d[b]  = '0;
                first_d[b] = 1'b1;
            end else if (prs[b]) begin
                armed_d[b] = 1'b1;
                hold_d[b]  = '0;
                first_d[b] = 1'b1;
            end else if (both_held) begin
                hold_d[b]  = '0;
                first_d[b] = 1'b1;
            end else if (armed_q[b]) begin
                if (hold_q[b] == (first_q[b] ? REPEAT_DELAY - 24'd1 : REPEAT_PERIOD - 24'd1)) begin
                    rep[b]     = 1'b1;
                    hold_d[b]  = '0;
                    first_d[b] = 1'b0;
                end else begin
                    hold_d[b] = hold_q[b] + 24'd1;
                end
            end
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            armed_q <= 2'b00;
            first_q <= 2'b11;
        end else begin
            hold_q  <= hold_d;
            armed_q <= armed_d;
            first_q <= first_d;
        end
    end
`else
    assign rep = 2'b00;
`endif

    // Arbitrate a single direction; anything with both buttons down is ignored.
    always_comb begin
        dir = DIR_NONE;
        if (!both_held) begin
            if (prs[1] | rep[1]) begin
                dir = DIR_RIGHT;
            end else if (prs[0] | rep[0]) begin
                dir = DIR_LEFT;
            end
        end
    end

    // Next position with rotate or saturate at the ends; step only when the position changes.
    always_comb begin
        pos_d  = pos_q;
        step_d = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                if (pos_q == POS_MAX) begin
                    if (WRAP) begin
                        pos_d  = '0;
                        step_d = 1'b1;
                    end
                end else begin
                    pos_d  = pos_q + 1'b1;
                    step_d = 1'b1;
                end
            end
            DIR_LEFT: begin
                if (pos_q == '0) begin
                    if (WRAP) begin
                        pos_d  = POS_MAX;
                        step_d = 1'b1;
                    end
                end else begin
                    pos_d  = pos_q - 1'b1;
                    step_d = 1'b1;
                end
            end
            default: begin
                pos_d  = pos_q;
                step_d = 1'b0;
            end
        endcase
    end

    // Position and step registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q  <= '0;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            step_q <= step_d;
        end
    end

    assign pos  = pos_q;
    assign step = step_q;
    assign led  = WIDTH'(1) << pos_q;

endmodule

// File: tb/tb_button_position.sv
// tb/tb_button_position.sv - self-checking bench for button_position (wrap and saturate instances)
module tb_button_position;

    localparam int DB   = 4;
    localparam int W    = 4;
    localparam int RD   = 40;
    localparam int RP   = 10;
    localparam int SETL = 1 << DB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b1  = 1'b1;
    logic       b2  = 1'b1;
    logic [3:0] led_w, led_s;
    logic [1:0] pos_w, pos_s;
    logic       step_w, step_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    button_position #(.WIDTH(W), .DB_BITS(DB), .WRAP(1'b1),
                      .REPEAT_DELAY(24'd40), .REPEAT_PERIOD(24'd10)) u_wrap (
        .clk(clk), .rst(rst), .button1(b1), .button2(b2),
        .led(led_w), .pos(pos_w), .step(step_w)
    );

    button_position #(.WIDTH(W), .DB_BITS(DB), .WRAP(1'b0),
                      .REPEAT_DELAY(24'd40), .REPEAT_PERIOD(24'd10)) u_sat (
        .clk(clk), .rst(rst), .button1(b1), .button2(b2),
        .led(led_s), .pos(pos_s), .step(step_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: buttons indexed 0=left, 1=right; configs 0=wrap, 1=saturate.
    bit model_ok = 1'b0;
    bit sync_m[2], st_m[2], prev_m[2];
    int run_m[2];
    int armed_m[2], t_m[2];
    int pos_m[2];
    bit step_m[2];

    always @(posedge clk) begin : model
        bit pr[2];
        bit rp[2];
        int dir;
        int np;
        if (rst) begin
            model_ok = 1'b1;
            for (int b = 0; b < 2; b++) begin
                sync_m[b] = 0; st_m[b] = 0; prev_m[b] = 0; run_m[b] = 0;
                armed_m[b] = 0; t_m[b] = 0; pos_m[b] = 0; step_m[b] = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                pr[b] = st_m[b] && !prev_m[b];
                rp[b] = 0;
`ifdef BUTTON_REPEAT_EN
                if (!st_m[b]) begin
                    armed_m[b] = 0; t_m[b] = 0;
                end else if (pr[b]) begin
                    armed_m[b] = 1; t_m[b] = 0;
                end else if (st_m[0] && st_m[1]) begin
                    t_m[b] = 0;
                end else if (armed_m[b] != 0) begin
                    t_m[b]++;
                    if (t_m[b] >= RD && ((t_m[b] - RD) % RP) == 0) rp[b] = 1;
                end
`endif
            end
            dir = 0;
            if (!(st_m[0] && st_m[1])) begin
                if (pr[1] || rp[1]) dir = 1;
                else if (pr[0] || rp[0]) dir = -1;
            end
            for (int c = 0; c < 2; c++) begin
                np = pos_m[c] + dir;
                if (c == 0) np = (np + W) % W;
                else if (np < 0) np = 0;
                else if (np > W - 1) np = W - 1;
                step_m[c] = (np != pos_m[c]);
                pos_m[c]  = np;
            end
            for (int b = 0; b < 2; b++) begin
                prev_m[b] = st_m[b];
                if (sync_m[b] != st_m[b]) run_m[b]++;
                else run_m[b] = 0;
                if (run_m[b] == SETL) begin
                    st_m[b]  = !st_m[b];
                    run_m[b] = 0;
                end
            end
            sync_m[0] = !b1;
            sync_m[1] = !b2;
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("pos_wrap",  pos_w,  pos_m[0]);
            chk("led_wrap",  led_w,  1 << pos_m[0]);
            chk("step_wrap", step_w, step_m[0]);
            chk("pos_sat",   pos_s,  pos_m[1]);
            chk("led_sat",   led_s,  1 << pos_m[1]);
            chk("step_sat",  step_s, step_m[1]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        if (b == 0) b1 = 1'b0;
        else        b2 = 1'b0;
        tick(25);
        b1 = 1'b1;
        b2 = 1'b1;
        tick(25);
    endtask

    task automatic wait_step(output int edges);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (step_w) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int e;
        int cnt;
        rst = 1'b1; b1 = 1'b1; b2 = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("reset_led", led_w, 4'b0001);
        chk("reset_pos", pos_w, 0);
        chk("reset_step", step_w, 0);

        // Short glitch must not move anything.
        b2 = 1'b0; tick(10); b2 = 1'b1; tick(25);
        chk("glitch_led", led_w, 4'b0001);

        // Clean press: step 18 edges after the change.
        b2 = 1'b0;
        wait_step(e);
        chk("press_latency", e, 18);
        chk("press_led", led_w, 4'b0010);
        b2 = 1'b1; tick(25);

        press(0);
        chk("left_pos", pos_w, 0);
        press(0);
        chk("wrap_left_led", led_w, 4'b1000);
        chk("wrap_left_pos", pos_w, 3);
        chk("sat_left_led", led_s, 4'b0001);
        press(1);
        for (int k = 0; k < 4; k++) press(1);
        chk("wrap_right_led", led_w, 4'b0001);
        chk("sat_right_led", led_s, 4'b1000);
        chk("model_sat_pos", pos_m[1], 3);
        press(0);
        chk("sat_back_pos", pos_s, 2);
        chk("wrap_back_pos", pos_w, 3);

        // Both buttons falling together: no movement.
        b1 = 1'b0; b2 = 1'b0; tick(25); b1 = 1'b1; b2 = 1'b1; tick(25);
        chk("simul_wrap", pos_w, 3);
        chk("simul_sat", pos_s, 2);

        // Left held (moves once), right press during hold discarded.
        b1 = 1'b0; tick(25);
        b2 = 1'b0; tick(25); b2 = 1'b1; tick(25);
        b1 = 1'b1; tick(25);
        chk("held_wrap", pos_w, 2);
        chk("held_sat", pos_s, 1);
        chk("model_wrap_pos", pos_m[0], 2);

`ifdef BUTTON_REPEAT_EN
        // Hold right: press step then repeats at +40, +50, +60, +70.
        b2 = 1'b0;
        wait_step(e);
        chk("rep_first_seen", (e != 0), 1);
        cnt = 1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (step_w) cnt++;
            if (i == 55) b2 = 1'b1;
        end
        chk("rep_count", cnt, 5);
        tick(30);
        chk("rep_led", led_w, 4'b1000);

        press(0); press(0);
        chk("rep_pre_pos", pos_w, 1);
        // Hold right again, reset at +45, release before debounce completes.
        b2 = 1'b0;
        wait_step(e);
        chk("rep2_first_seen", (e != 0), 1);
        tick(44);
        chk("rep2_led_before_rst", led_w, 4'b1000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rep2_rst_led", led_w, 4'b0001);
        tick(2);
        b2 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (step_w) cnt++;
        end
        chk("rep2_no_steps", cnt, 0);
        press(1);
        chk("rep2_repress_pos", pos_w, 1);
`endif

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_position.md
# button_position

Parametrised two-button position controller. It debounces two raw, active-low push-buttons (left/right) and moves a one-hot position across a WIDTH-bit LED bank. The position either rotates at the ends or saturates there, and optional hold-to-repeat stepping is available. It sits between board button pins and the LED/indicator outputs, and serves as the general position-input block for UI examples.

## Interface
- WIDTH, 4: number of positions and LED outputs (≥2).
- DB_BITS, 16: debounce counter width; the settle time is 2^DB_BITS cycles.
- WRAP, 1: 1 = rotate at the ends; 0 = saturate at the ends.
- REPEAT_DELAY, 24'd6_000_000: cycles a button is held before the first auto-repeat step (repeat builds only).
- REPEAT_PERIOD, 24'd1_500_000: cycles between subsequent repeat steps (repeat builds only).
- clk  input  1  system clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- button1  input  1  raw left button, active-low, asynchronous.
- button2  input  1  raw right button, active-low, asynchronous.
- led  output  WIDTH  one-hot position.
- pos  output  $clog2(WIDTH)  binary index of the set led bit.
- step  output  1  one-cycle pulse in the cycle led/pos take a new value.

## Operation
- Debounce, per button:
  - sync <= ~raw.
  - Counter clears while sync == state; otherwise it increments.
  - When the counter is all-ones, state toggles on the next edge.
  - A glitch shorter than 2^DB_BITS cycles never changes state.
- Press event = debounced state rising (0→1), detected against a registered copy of the state.
- Right press: position index +1 (led rotates toward the MSB). Left press: index −1.
- At the ends:
  - WRAP=1: index WIDTH−1 +1 → 0, and 0 −1 → WIDTH−1.
  - WRAP=0: the index holds at the end, and step is not pulsed.
- Both debounced states high: no movement. A press event on one button while the other is held is discarded.
- Both press events in the same cycle: no movement, no step.
- Release events never move the position.
- led always equals 1 << pos. One-hot is maintained by construction.

## Timing
- Reset values: led = 1 (bit 0), pos = 0, step = 0. All debounce states = 0, sync = 0, counters = 0, repeat counters = 0.
- rst mid-debounce or mid-hold: all state is cleared within that edge. A button still held after reset is seen as pressed once it passes a full debounce again; the first press event follows from the 0 reset state.
- Latency:
  - A raw change held stable reaches the debounced state on the (2^DB_BITS + 1)th edge after the change is sampled.
  - led/pos/step update one edge after that.
- step is registered and coincides with the first cycle of the new led/pos value.
- At most one step per cycle.

## Configuration
- BUTTON_REPEAT_EN defined:
  - A per-button hold counter starts at the press event.
  - At REPEAT_DELAY cycles held, the block generates a step in the pressed direction, then one every REPEAT_PERIOD cycles while the button is held.
  - The hold counter clears on release, on rst, and while both buttons are held.
  - Repeat steps obey WRAP/saturate exactly like press steps.
- BUTTON_REPEAT_EN undefined: hold counters and parameters are unused, and only press events move the position.

## Structure
- Shared package button_pkg holds:
  - default constants DB_BITS_DEF = 16, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF
  - direction encoding typedef dir_t {DIR_NONE, DIR_LEFT, DIR_RIGHT}
- One sub-module, btn_debounce:
  - parameter DB_BITS
  - ports clk, rst, button (raw active-low), state (debounced, active-high), press (one-cycle rising pulse)
  - instantiated twice
- Top level: direction arbitration, optional repeat timers, position register.

## Test plan
Run with DB_BITS=4 (settle time 16 cycles), WIDTH=4, REPEAT_DELAY=40, REPEAT_PERIOD=10.
- Reset: assert rst for 2 cycles with both buttons released (high) → led=4'b0001, pos=0, step=0.
- Debounce:
  - button2 pulled low for 10 cycles, then released → no step, led=4'b0001.
  - button2 held low → step pulses once, 18 edges after the change is sampled; led=4'b0010.
- Wrap: WRAP=1, start at pos=0, one clean button1 press → led=4'b1000, pos=3. Four button2 presses from pos=0 → back to led=4'b0001.
- Saturate: WRAP=0, at pos=3, press button2 → led stays 4'b1000, no step. Press button1 → pos=2.
- Simultaneous: both buttons fall in the same cycle → no movement. With button1 held, press button2 → no movement.
- Repeat (BUTTON_REPEAT_EN): hold button2 for 80 cycles past debounce → steps at press, +40, +50, +60, +70 (5 steps); led rotates accordingly. Asserting rst at +45 → led=4'b0001, and no further steps until the button is released and pressed again.
